// File: rtl/synaptic_update_scheduler_if.sv
// Control/strobe bundle between the training sequencer and the synaptic update scheduler.
// The slave modport is the scheduler's view; the master modport is the upstream or test driver.
interface synaptic_update_scheduler_if #(
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10
);
  logic                            i_is_train;
  logic                            i_start;
  logic                            i_abort;
  logic                            o_busy;
  logic                            o_done;
  logic                            o_synarray_cs;
  logic                            o_synarray_we;
  logic                            o_grad_array_cs;
  logic                            o_grad_array_we;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] o_synarray_addr;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]  o_pre_neuron_address;
  logic [POST_NEUR_ADDR_WIDTH-1:0] o_post_neuron_address;
  logic                            o_tref_event;

  modport master (
    output i_is_train, i_start, i_abort,
    input  o_busy, o_done, o_synarray_cs, o_synarray_we, o_grad_array_cs, o_grad_array_we,
    input  o_synarray_addr, o_pre_neuron_address, o_post_neuron_address, o_tref_event
  );

  modport slave (
    input  i_is_train, i_start, i_abort,
    output o_busy, o_done, o_synarray_cs, o_synarray_we, o_grad_array_cs, o_grad_array_we,
    output o_synarray_addr, o_pre_neuron_address, o_post_neuron_address, o_tref_event
  );
endinterface

// File: rtl/synaptic_update_scheduler.sv
// Sweeps every weight/gradient SRAM word with a READ/WAIT/WRITE read-modify-write after a training
// sample, driving the synaptic_core strobes and the pre/post neuron addresses for each word.
module synaptic_update_scheduler #(
  parameter int INPUT_NEURON         = 784,
  parameter int OUTPUT_NEURON        = 256,
  parameter int POST_NEUR_PARALLEL   = 4,
  parameter int SYN_ARRAY_ADDR_WIDTH = 16,
  parameter int PRE_NEUR_ADDR_WIDTH  = 10,
  parameter int POST_NEUR_ADDR_WIDTH = 10
) (
  input logic                     i_clk,
  input logic                     i_rst,
  synaptic_update_scheduler_if.slave bus
);

  localparam int GROUPS = OUTPUT_NEURON / POST_NEUR_PARALLEL;
  localparam int WORDS  = INPUT_NEURON * GROUPS;
  localparam int GRP_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;

  localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] ADDR_LAST = SYN_ARRAY_ADDR_WIDTH'(WORDS - 1);
  localparam logic [SYN_ARRAY_ADDR_WIDTH-1:0] ADDR_ONE  = SYN_ARRAY_ADDR_WIDTH'(1);
  localparam logic [PRE_NEUR_ADDR_WIDTH-1:0]  PRE_ONE   = PRE_NEUR_ADDR_WIDTH'(1);
  localparam logic [GRP_W-1:0]                GRP_LAST  = GRP_W'(GROUPS - 1);
  localparam logic [GRP_W-1:0]                GRP_ONE   = GRP_W'(1);
  localparam logic [POST_NEUR_ADDR_WIDTH-1:0] POST_STEP = POST_NEUR_ADDR_WIDTH'(POST_NEUR_PARALLEL);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_READ  = 3'd1,
    S_WAIT  = 3'd2,
    S_WRITE = 3'd3,
    S_FIN   = 3'd4
  } state_t;

  state_t                          r_state;
  state_t                          w_state_next;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]  r_pre;
  logic [PRE_NEUR_ADDR_WIDTH-1:0]  w_pre_next;
  logic [GRP_W-1:0]                r_grp;
  logic [GRP_W-1:0]                w_grp_next;
  // Post address and word address advance as their own registers so no multiplier is needed.
  logic [POST_NEUR_ADDR_WIDTH-1:0] r_post;
  logic [POST_NEUR_ADDR_WIDTH-1:0] w_post_next;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] r_addr;
  logic [SYN_ARRAY_ADDR_WIDTH-1:0] w_addr_next;
  logic                            w_clear;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_pre   <= '0;
      r_grp   <= '0;
      r_post  <= '0;
      r_addr  <= '0;
    end else begin
      r_state <= w_state_next;
      r_pre   <= w_pre_next;
      r_grp   <= w_grp_next;
      r_post  <= w_post_next;
      r_addr  <= w_addr_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_clear      = 1'b0;
    w_pre_next   = r_pre;
    w_grp_next   = r_grp;
    w_post_next  = r_post;
    w_addr_next  = r_addr;

    case (r_state)
      S_IDLE: begin
        // Abort outranks start even in idle, so a coincident pair never launches a sweep.
        if (bus.i_start && bus.i_is_train && !bus.i_abort) begin
          w_state_next = S_READ;
          w_clear      = 1'b1;
        end
      end
      S_READ: begin
        if (bus.i_abort) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.i_abort) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        // The write strobes of this cycle go out regardless; abort only decides what follows.
        if (bus.i_abort) begin
          w_state_next = S_IDLE;
          w_clear      = 1'b1;
        end else if (r_addr == ADDR_LAST) begin
          w_state_next = S_FIN;
          w_clear      = 1'b1;
        end else begin
          w_state_next = S_READ;
          w_addr_next  = r_addr + ADDR_ONE;
          if (r_grp == GRP_LAST) begin
            w_grp_next  = '0;
            w_post_next = '0;
            w_pre_next  = r_pre + PRE_ONE;
          end else begin
            w_grp_next  = r_grp + GRP_ONE;
            w_post_next = r_post + POST_STEP;
          end
        end
      end
      S_FIN: begin
        w_state_next = S_IDLE;
      end
      default: begin
        w_state_next = S_IDLE;
        w_clear      = 1'b1;
      end
    endcase

    if (w_clear) begin
      w_pre_next  = '0;
      w_grp_next  = '0;
      w_post_next = '0;
      w_addr_next = '0;
    end
  end

  logic w_busy;
  logic w_cs;
  logic w_we;

  always_comb begin
    w_busy = 1'b0;
    w_cs   = 1'b0;
    w_we   = 1'b0;
    case (r_state)
      S_READ:  begin w_busy = 1'b1; w_cs = 1'b1; end
      S_WAIT:  begin w_busy = 1'b1; end
      S_WRITE: begin w_busy = 1'b1; w_cs = 1'b1; w_we = 1'b1; end
      default: begin end
    endcase
  end

  assign bus.o_busy                = w_busy;
  assign bus.o_done                = (r_state == S_FIN);
  assign bus.o_synarray_cs         = w_cs;
  assign bus.o_synarray_we         = w_we;
  assign bus.o_grad_array_cs       = w_cs;
  assign bus.o_grad_array_we       = w_we;
  assign bus.o_tref_event          = w_we;
  assign bus.o_synarray_addr       = r_addr;
  assign bus.o_pre_neuron_address  = r_pre;
  assign bus.o_post_neuron_address = r_post;

endmodule
